d_ff_latch_bank: RTL and testbench

D_FF_LATCH_BANK -- requirements
Module: d_ff_latch_bank

---
 rtl/d_ff_latch_bank.sv | 72 +++++++
 tb/tb_d_ff_latch_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/d_ff_latch_bank.sv
// d_ff_latch_bank: WIDTH-wide clocked SR latch, D latch and master-slave
// flip-flop sharing one clock/enable C, async active-low reset nR and
// async active-low preset nP. Every bit-slice is independent, so each
// slice is built in its own generate block with its own storage nodes.
// All storage is level-sensitive. Reset and preset override the enable
// directly, so outputs are defined from time zero and releasing either
// one leaves the stored value in place until C enables the stage again.
module d_ff_latch_bank #(
   parameter int WIDTH = 1
) (
   input  logic             C,
   input  logic             nR,
   input  logic             nP,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] DFF,
   output logic [WIDTH-1:0] srQ,
   output logic [WIDTH-1:0] srnQ,
   output logic [WIDTH-1:0] dQ,
   output logic [WIDTH-1:0] dnQ,
   output logic [WIDTH-1:0] dffQ,
   output logic [WIDTH-1:0] dffnQ
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      logic sr_q, sr_d, sr_en;
      logic d_q;
      logic m_q, s_q;

      // SR latch only writes when S or R is asserted; R wins when both are
      // set, so the written value is simply S and not R.
      assign sr_en = C & (S[i] | R[i]);
      assign sr_d  = S[i] & ~R[i];

      // SR latch storage: reset beats preset, both beat the enable
      always_latch begin
         if (!nR)        sr_q <= 1'b0;
         else if (!nP)   sr_q <= 1'b1;
         else if (sr_en) sr_q <= sr_d;
      end

      // D latch storage: transparent while C is high
      always_latch begin
         if (!nR)      d_q <= 1'b0;
         else if (!nP) d_q <= 1'b1;
         else if (C)   d_q <= D[i];
      end

      // Flip-flop master: tracks DFF while C is low, freezes on the rise
      always_latch begin
         if (!nR)      m_q <= 1'b0;
         else if (!nP) m_q <= 1'b1;
         else if (!C)  m_q <= DFF[i];
      end

      // Flip-flop slave: copies the frozen master while C is high
      always_latch begin
         if (!nR)      s_q <= 1'b0;
         else if (!nP) s_q <= 1'b1;
         else if (C)   s_q <= m_q;
      end

      assign srQ[i]   = sr_q;
      assign srnQ[i]  = ~sr_q;
      assign dQ[i]    = d_q;
      assign dnQ[i]   = ~d_q;
      assign dffQ[i]  = s_q;
      assign dffnQ[i] = ~s_q;
   end

endmodule

// File: tb/tb_d_ff_latch_bank.sv
// Bench for d_ff_latch_bank: a WIDTH=4 and a WIDTH=1 instance share the
// stimulus (the narrow one sees bit 0). A directed table walks the
// reset/preset, edge, transparency and priority sequences, then random
// single-field steps are checked against a level/edge behavioural model.
module tb_d_ff_latch_bank;

   logic       c, nr, np;
   logic [3:0] s, r, d, dff;
   logic [3:0] srq4, srnq4, dq4, dnq4, dffq4, dffnq4;
   logic [0:0] srq1, srnq1, dq1, dnq1, dffq1, dffnq1;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural expectations
   logic [3:0] e_sr, e_d, e_dff;
   logic       prev_c;

   d_ff_latch_bank #(.WIDTH(4)) u4 (
      .C(c), .nR(nr), .nP(np), .S(s), .R(r), .D(d), .DFF(dff),
      .srQ(srq4), .srnQ(srnq4), .dQ(dq4), .dnQ(dnq4),
      .dffQ(dffq4), .dffnQ(dffnq4)
   );

   d_ff_latch_bank #(.WIDTH(1)) u1 (
      .C(c), .nR(nr), .nP(np), .S(s[0:0]), .R(r[0:0]), .D(d[0:0]),
      .DFF(dff[0:0]),
      .srQ(srq1), .srnQ(srnq1), .dQ(dq1), .dnQ(dnq1),
      .dffQ(dffq1), .dffnQ(dffnq1)
   );

   typedef struct {
      logic       c, nr, np;
      logic [3:0] s, r, d, dff;
      logic [3:0] esr, ed, edff;
   } vec_t;

   function automatic vec_t mk(input logic c_, nr_, np_,
                               input logic [3:0] s_, r_, d_, dff_,
                               input logic [3:0] esr_, ed_, edff_);
      vec_t v;
      v.c = c_; v.nr = nr_; v.np = np_;
      v.s = s_; v.r = r_; v.d = d_; v.dff = dff_;
      v.esr = esr_; v.ed = ed_; v.edff = edff_;
      return v;
   endfunction

   // Reset wins, then preset; otherwise SR and D act on the C level
   // (R clears, S sets, neither holds) and the flop takes DFF on a rise.
   task automatic model_step();
      if (!nr) begin
         e_sr = '0; e_d = '0; e_dff = '0;
      end else if (!np) begin
         e_sr = '1; e_d = '1; e_dff = '1;
      end else begin
         if (c) begin
            e_sr = (e_sr | s) & ~r;
            e_d  = d;
         end
         if (c && !prev_c) e_dff = dff;
      end
      prev_c = c;
   endtask

   task automatic check(input string name, input logic [3:0] xsr,
                        input logic [3:0] xd, input logic [3:0] xdff);
      logic [23:0] got4, exp4;
      logic [5:0]  got1, exp1;
      got4 = {srq4, srnq4, dq4, dnq4, dffq4, dffnq4};
      exp4 = {xsr, ~xsr, xd, ~xd, xdff, ~xdff};
      got1 = {srq1, srnq1, dq1, dnq1, dffq1, dffnq1};
      exp1 = {xsr[0], ~xsr[0], xd[0], ~xd[0], xdff[0], ~xdff[0]};
      n_tests++;
      if (got4 !== exp4) begin
         n_fail++;
         $display("FAIL %s W4 {sr,srn,d,dn,dff,dffn} got=%h exp=%h", name, got4, exp4);
      end
      n_tests++;
      if (got1 !== exp1) begin
         n_fail++;
         $display("FAIL %s W1 {sr,srn,d,dn,dff,dffn} got=%b exp=%b", name, got1, exp1);
      end
   endtask

   vec_t tbl[30];

   initial begin
      // power-up with reset and preset both asserted from time zero
      c = 0; nr = 0; np = 0; s = '0; r = '0; d = '0; dff = '0;
      e_sr = '0; e_d = '0; e_dff = '0; prev_c = 0;

      //            C  nR nP  S     R     D     DFF    sr    d     dff
      // reset/preset sweep with C low
      tbl[0]  = mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[1]  = mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[2]  = mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
      tbl[3]  = mk(0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF);
      // reset, release, data with C low, then rising and falling edge
      tbl[4]  = mk(0, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[5]  = mk(0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[6]  = mk(0, 1, 1, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
      tbl[7]  = mk(1, 1, 1, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
      tbl[8]  = mk(0, 1, 1, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
      // transparency with C held high
      tbl[9]  = mk(0, 1, 1, 4'h0, 4'hF, 4'h0, 4'hA, 4'hF, 4'hF, 4'hF);
      tbl[10] = mk(1, 1, 1, 4'h0, 4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
      tbl[11] = mk(1, 1, 1, 4'hF, 4'h0, 4'hF, 4'h5, 4'hF, 4'hF, 4'hA);
      tbl[12] = mk(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hA);
      tbl[13] = mk(1, 1, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hA);
      tbl[14] = mk(1, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA);
      tbl[15] = mk(1, 1, 1, 4'h3, 4'hC, 4'h6, 4'h0, 4'h3, 4'h6, 4'hA);
      tbl[16] = mk(1, 1, 1, 4'h0, 4'h1, 4'h9, 4'h0, 4'h2, 4'h9, 4'hA);
      // falling edge does not capture; next rise does
      tbl[17] = mk(1, 1, 1, 4'h0, 4'h1, 4'h9, 4'hF, 4'h2, 4'h9, 4'hA);
      tbl[18] = mk(0, 1, 1, 4'h0, 4'h1, 4'h9, 4'hF, 4'h2, 4'h9, 4'hA);
      tbl[19] = mk(1, 1, 1, 4'h0, 4'h1, 4'h9, 4'hF, 4'h2, 4'h9, 4'hF);
      tbl[20] = mk(1, 1, 1, 4'h0, 4'h1, 4'h9, 4'h0, 4'h2, 4'h9, 4'hF);
      tbl[21] = mk(0, 1, 1, 4'h0, 4'h1, 4'h9, 4'h0, 4'h2, 4'h9, 4'hF);
      tbl[22] = mk(1, 1, 1, 4'h0, 4'h1, 4'h9, 4'h0, 4'h2, 4'h9, 4'h0);
      // S=R=1 is reset-dominant; reset beats preset with C high
      tbl[23] = mk(1, 1, 1, 4'hF, 4'hF, 4'h9, 4'h0, 4'h0, 4'h9, 4'h0);
      tbl[24] = mk(1, 1, 1, 4'hF, 4'h0, 4'h9, 4'h0, 4'hF, 4'h9, 4'h0);
      tbl[25] = mk(1, 0, 0, 4'hF, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
      tbl[26] = mk(1, 1, 0, 4'hF, 4'h0, 4'h9, 4'h0, 4'hF, 4'hF, 4'hF);
      tbl[27] = mk(1, 1, 1, 4'hF, 4'h0, 4'h9, 4'h0, 4'hF, 4'h9, 4'hF);
      // first edge after preset release captures fresh DFF
      tbl[28] = mk(0, 1, 1, 4'hF, 4'h0, 4'h9, 4'h0, 4'hF, 4'h9, 4'hF);
      tbl[29] = mk(1, 1, 1, 4'hF, 4'h0, 4'h9, 4'h0, 4'hF, 4'h9, 4'h0);

      for (int i = 0; i < 30; i++) begin
         c = tbl[i].c; nr = tbl[i].nr; np = tbl[i].np;
         s = tbl[i].s; r = tbl[i].r; d = tbl[i].d; dff = tbl[i].dff;
         #5;
         model_step();
         check($sformatf("vec%0d", i), tbl[i].esr, tbl[i].ed, tbl[i].edff);
         #5;
      end

      // random single-field steps so edges never coincide with data changes
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: c = ~c;
            4, 5, 6, 7: begin
               s = 4'($urandom); r = 4'($urandom);
               d = 4'($urandom); dff = 4'($urandom);
            end
            8:       nr = ($urandom_range(0, 3) != 0);
            default: np = ($urandom_range(0, 3) != 0);
         endcase
         #5;
         model_step();
         check("rand", e_sr, e_d, e_dff);
         #5;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
